// File: rtl/unary_binary_mxu_rect.sv
// -----------------------------------------------------------------------------
// unary_binary_mxu_rect
//
// Temporal (unary-binary) matrix multiply unit for a rectangular operand pair:
// C[M][N] = A[M][K] x B[K][N]. A is consumed as a thermometer code, one step
// per cycle: on step t every A element that is still greater than t lets its
// B row through to the accumulator. After 2^BIT_WIDTH-1 steps each product
// A*B has been added exactly A times. B stays in binary throughout.
//
// The result is held at full width OUT_W (no truncation) and wraps modulo
// 2^OUT_W. An accepted start with acc_en=1 adds the new product onto the held
// result instead of clearing it first.
//
// Optional build macro: UNARY_MXU_EARLY_TERM_EN
//   When defined, the start edge also latches the largest A element and RUN
//   ends after max(1, maxA) steps; later steps could not contribute anyway,
//   so the result is identical.
//
// Ports
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   start      in   begin a computation (sampled only while idle)
//   acc_en     in   sampled with start: 1 = accumulate, 0 = clear first
//   A          in   [M][K] unsigned operand, captured on the accepted start
//   B          in   [K][N] unsigned operand, captured on the accepted start
//   busy       out  high while running or holding an unconsumed result
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
//   out        out  [M][N] result matrix, OUT_W bits per element
// -----------------------------------------------------------------------------
module unary_binary_mxu_rect #(
    parameter int BIT_WIDTH = 4,
    parameter int M         = 2,
    parameter int K         = 2,
    parameter int N         = 2,
    parameter int OUT_W     = 12
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic                                 acc_en,
    input  logic [M-1:0][K-1:0][BIT_WIDTH-1:0]   A,
    input  logic [K-1:0][N-1:0][BIT_WIDTH-1:0]   B,
    output logic                                 busy,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [M-1:0][N-1:0][OUT_W-1:0]       out
);

    // Widest per-step contribution: K terms of at most 2^BIT_WIDTH-1 each.
    localparam int PSUM_W = BIT_WIDTH + $clog2(K);

    generate
        if (OUT_W < 2 * BIT_WIDTH + $clog2(K)) begin : g_out_w_check
            $error("unary_binary_mxu_rect: OUT_W too small to hold the full-width product sum");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                                  r_state;
    state_t                                  w_next_state;

    logic [M-1:0][K-1:0][BIT_WIDTH-1:0]      r_a;
    logic [K-1:0][N-1:0][BIT_WIDTH-1:0]      r_b;
    logic [BIT_WIDTH-1:0]                    r_t;
    logic [M-1:0][N-1:0][OUT_W-1:0]          r_out;

    logic                                    w_start_accept;
    logic                                    w_run_last;
    logic [BIT_WIDTH-1:0]                    w_t_last;
    logic [M-1:0][N-1:0][PSUM_W-1:0]         w_psum;

    assign w_start_accept = (r_state == ST_IDLE) && start;

    // -------------------------------------------------------------------------
    // Last RUN step
    // -------------------------------------------------------------------------
`ifdef UNARY_MXU_EARLY_TERM_EN
    logic [BIT_WIDTH-1:0] w_max_a;
    logic [BIT_WIDTH-1:0] r_max_a;

    always_comb begin
        w_max_a = '0;
        for (int i = 0; i < M; i++) begin
            for (int k = 0; k < K; k++) begin
                if (A[i][k] > w_max_a) begin
                    w_max_a = A[i][k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_max_a <= '0;
        end else if (w_start_accept) begin
            r_max_a <= w_max_a;
        end
    end

    // RUN always takes at least one step, even when every A element is zero.
    assign w_t_last = (r_max_a == '0) ? '0 : r_max_a - BIT_WIDTH'(1);
`else
    // 2^BIT_WIDTH-2: the last step index before t would reach all-ones.
    localparam logic [BIT_WIDTH-1:0] T_LAST = ~BIT_WIDTH'(1);

    assign w_t_last = T_LAST;
`endif

    assign w_run_last = (r_state == ST_RUN) && (r_t == w_t_last);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment up front keeps this block free of latches
    // on any path that does not assign w_next_state explicitly.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (start)      w_next_state = ST_RUN;
            ST_RUN:  if (w_run_last) w_next_state = ST_DONE;
            ST_DONE: if (out_ready)  w_next_state = ST_IDLE;
            default:                 w_next_state = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = (r_state != ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    assign out = r_out;

    // -------------------------------------------------------------------------
    // Per-step partial sums: row k of B passes while A[i][k] still exceeds t.
    // -------------------------------------------------------------------------
    always_comb begin
        w_psum = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < K; k++) begin
                    if (r_t < r_a[i][k]) begin
                        w_psum[i][j] = w_psum[i][j] + PSUM_W'(r_b[k][j]);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Operand capture, step counter and accumulator
    // -------------------------------------------------------------------------
    // NOTE: the operand registers are reset along with the control state so a
    // reset leaves no stale operands to leak into a later computation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_t   <= '0;
            r_out <= '0;
        end else if (w_start_accept) begin
            r_a <= A;
            r_b <= B;
            r_t <= '0;
            if (!acc_en) begin
                r_out <= '0;
            end
        end else if (r_state == ST_RUN) begin
            r_t <= r_t + BIT_WIDTH'(1);
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    // Silent wrap modulo 2^OUT_W.
                    r_out[i][j] <= r_out[i][j] + OUT_W'(w_psum[i][j]);
                end
            end
        end
    end

endmodule

// File: doc/unary_binary_mxu_rect.md
Name: unary_binary_mxu_rect

Overview:
- Parametrised successor to the temporal (unary-binary) matrix multiply unit.
- Computes C = A×B for a rectangular M×K by K×N operand pair.
  - A is decoded as a thermometer (unary) stream, one step per cycle.
  - B is applied in binary.
- Adds a full-width output (no truncation), output back-pressure, accumulate mode and a busy flag.
- Sits between the operand buffers and the result writeback in the MXU datapath.

Parameters:
- BIT_WIDTH, 4, unsigned operand width.
- M, 2, rows of A and C.
- K, 2, columns of A / rows of B (reduction depth).
- N, 2, columns of B and C.
- OUT_W, 12, result element width; must be >= 2*BIT_WIDTH+$clog2(K); elaboration error otherwise.

Ports:
- clk  in  1  clock.
- reset_n  in  1  active-low reset.
- start  in  1  request a new computation; sampled only in IDLE.
- acc_en  in  1  sampled with start; 1 = add new products to the held out, 0 = clear first.
- A  in  [M-1:0][K-1:0][BIT_WIDTH-1:0]  operand A, captured on the accepted start.
- B  in  [K-1:0][N-1:0][BIT_WIDTH-1:0]  operand B, captured on the accepted start.
- busy  out  1  high in RUN and DONE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out  out  [M-1:0][N-1:0][OUT_W-1:0]  result matrix C.

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous, active-low.
- Reset values: state=IDLE, busy=0, out_valid=0, out=0, step counter t=0, operand registers=0.
- IDLE:
  - start=1 captures A, B into registers and sets t=0.
  - If acc_en=0, out is cleared at the same edge; if acc_en=1, out is kept.
  - Next state RUN.
- RUN, each cycle:
  - For every (i,j): out[i][j] += sum over k of ((t < A[i][k]) ? B[k][j] : 0), modulo 2^OUT_W.
  - t increments by 1.
  - When t == 2^BIT_WIDTH-2, the same edge moves to DONE.
  - RUN therefore lasts exactly 2^BIT_WIDTH-1 cycles.
- Latency: out_valid rises 2^BIT_WIDTH-1 edges after the start edge (15 for BIT_WIDTH=4).
- DONE:
  - out_valid=1 and out is stable.
  - When out_valid && out_ready, go to IDLE at that edge; out_valid=0 and out is held (needed for accumulate).
- start is ignored in RUN and DONE. A and B may change freely after the capture edge.
- Arithmetic:
  - Operands are unsigned.
  - Per-cycle partial-sum width is BIT_WIDTH+$clog2(K).
  - Accumulator wraps silently; there is no saturation.
- Boundary cases:
  - A element 0 contributes nothing.
  - A element 2^BIT_WIDTH-1 contributes on all steps.
  - K=1 is legal.
- Reset mid-RUN or mid-DONE: returns immediately to the reset values; the partial result is discarded.

Optional Feature:
- Macro: UNARY_MXU_EARLY_TERM_EN.
- Defined:
  - The start edge also registers maxA = maximum over all A elements.
  - RUN exits to DONE after max(1, maxA) cycles.
  - Latency = max(1, maxA); results are identical to the non-early-terminating case.
- Undefined: fixed 2^BIT_WIDTH-1 RUN cycles, and no maxA logic is synthesised.

Test Plan:
1. Default params: A=[[2,8],[12,14]], B=[[6,12],[12,9]], acc_en=0, out_ready=1 -> out_valid exactly 15 cycles after start; out=[[108,96],[240,270]]; busy drops the cycle after.
2. A and B all 15 -> out all 450. A all 0 -> out all 0, still 15-cycle latency without the macro.
3. Run test 1, then start again with the same operands and acc_en=1 -> out=[[216,192],[480,540]]. Then acc_en=0 -> back to [[108,96],[240,270]].
4. out_ready=0 for 5 cycles after out_valid, with start=1 pulsed during DONE -> out_valid and out held; start ignored; result consumed when out_ready=1; IDLE next cycle.
5. reset_n low 7 cycles into RUN -> busy=0, out_valid=0, out=0 immediately. A fresh start with test 1 operands gives the correct result after 15 cycles.
6. With UNARY_MXU_EARLY_TERM_EN:
   - A=[[1,3],[2,0]], B=[[1,1],[1,1]] -> out_valid after 3 cycles; out=[[4,4],[2,2]].
   - A all 0 -> out_valid after 1 cycle; out=0.
